instr_fetch: RTL and testbench

Instruction fetch stage of the 8-bit microprocessor. It holds the program counter and fetches 8-bit instruction words from instruction memory over a req/ack handshake. It presents each word, with its 2-bit opcode, to the downstream control/decode stage over a valid/ready handshake. It also accepts branch redirects from execute, flushing any instruction that is held or in flight.

---
 rtl/microprocessor_pkg.sv | 31 +++
 rtl/instr_fetch_if.sv | 41 ++++
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/microprocessor_pkg.sv
// Shared definitions for the 8-bit microprocessor.
// Contents: instruction width, opcode encodings (shared with the control
// block), instruction field bit positions and the fetch-stage state encoding.
package microprocessor_pkg;

    localparam int INSTR_W = 8;

    // Opcode encodings carried in instr[7:6]
    localparam logic [1:0] OP_ALU    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    // Instruction field bit positions: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RS_MSB = 5;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 2;
    localparam int RD_MSB = 1;
    localparam int RD_LSB = 0;

    // Fetch-stage states
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Handshake bundle around the instruction fetch stage.
// Groups the instruction-memory req/ack bus, the valid/ready link to decode
// and the branch redirect input from execute.
//   master : the fetch stage (drives imem_req/imem_addr and the instr outputs)
//   slave  : the environment (memory, decode and execute)
interface instr_fetch_if
    import microprocessor_pkg::*;
#(
    parameter int PC_W = 8
);
    // instruction memory
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    // decode link
    logic [INSTR_W-1:0] instr;
    logic [1:0]         op;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    // branch redirect from execute
    logic               redirect;
    logic [PC_W-1:0]    redirect_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr, op, instr_pc, instr_valid,
        input  instr_ready,
        input  redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr, op, instr_pc, instr_valid,
        output instr_ready,
        output redirect, redirect_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Holds the program counter, fetches one instruction word at a time over the
// imem req/ack bus, and holds it for decode on a valid/ready link. A redirect
// from execute reloads the PC and squashes any held or in-flight instruction.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : instr_fetch_if.master (imem bus, decode link, redirect)
module instr_fetch
    import microprocessor_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_t       state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [PC_W-1:0]    drain_addr_reg, drain_addr_next;
    logic [PC_W-1:0]    instr_pc_reg, instr_pc_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= REQ;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= RESET_PC;
            instr_pc_reg   <= '0;
            instr_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            instr_pc_reg   <= instr_pc_next;
            instr_reg      <= instr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        instr_pc_next   = instr_pc_reg;
        instr_next      = instr_reg;
        case (state_reg)
            REQ: begin
                if (bus.imem_ack && bus.redirect) begin
                    // response belongs to the wrong path: drop it, refetch at target
                    pc_next = bus.redirect_target;
                end else if (bus.imem_ack) begin
                    instr_next    = bus.imem_rdata;
                    instr_pc_next = pc_reg;
                    pc_next       = pc_reg + PC_W'(1);
                    state_next    = HOLD;
                end else if (bus.redirect) begin
                    // request still open: keep presenting the old address until it acks
                    drain_addr_next = pc_reg;
                    pc_next         = bus.redirect_target;
                    state_next      = DRAIN;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    pc_next    = bus.redirect_target;
                    state_next = REQ;
                end else if (bus.instr_ready) begin
                    state_next = REQ;
                end
            end
            DRAIN: begin
                if (bus.redirect) begin
                    pc_next = bus.redirect_target;
                end
                if (bus.imem_ack) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // Request is masked while reset is held so nothing is issued during reset,
    // and rises combinationally as soon as reset releases.
    assign bus.imem_req    = reset && (state_reg != HOLD);
    assign bus.imem_addr   = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
    assign bus.instr_valid = (state_reg == HOLD);
    assign bus.instr       = instr_reg;
    assign bus.instr_pc    = instr_pc_reg;
    assign bus.op          = bus.instr_valid ? instr_reg[OP_MSB:OP_LSB] : 2'b00;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: reset/first fetch, backpressure,
// PC wrap, redirects in HOLD/REQ/DRAIN and asynchronous reset mid-fetch.
module tb_instr_fetch;
    import microprocessor_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(8)) bus ();

    instr_fetch #(.PC_W(8), .RESET_PC(8'h10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string tag);
        $display("%s: req=%0b addr=%02h valid=%0b instr=%02h op=%0b instr_pc=%02h",
                 tag, bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.op, bus.instr_pc);
    endtask

    task automatic test_reset;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h10) begin failures++; $display("FAIL rst_addr got=%02h exp=10", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.instr !== 8'h00) begin failures++; $display("FAIL rst_instr got=%02h exp=00", bus.instr); end
        checks++; if (bus.instr_pc !== 8'h00) begin failures++; $display("FAIL rst_instr_pc got=%02h exp=00", bus.instr_pc); end
        checks++; if (bus.op !== 2'b00) begin failures++; $display("FAIL rst_op got=%0b exp=00", bus.op); end
        reset = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%0b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h10) begin failures++; $display("FAIL first_addr got=%02h exp=10", bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h5A;
        step();
        bus.imem_ack = 1'b0;
        show("first fetch");
        checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0b exp=1", bus.instr_valid); end
        checks++; if (bus.instr !== 8'h5A) begin failures++; $display("FAIL first_instr got=%02h exp=5A", bus.instr); end
        checks++; if (bus.op !== OP_LOAD) begin failures++; $display("FAIL first_op got=%0b exp=01", bus.op); end
        checks++; if (bus.instr_pc !== 8'h10) begin failures++; $display("FAIL first_instr_pc got=%02h exp=10", bus.instr_pc); end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL first_hold_req got=%0b exp=0", bus.imem_req); end
    endtask

    task automatic test_backpressure;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, bus.instr_valid); end
            checks++; if (bus.instr !== 8'h5A) begin failures++; $display("FAIL bp_instr[%0d] got=%02h exp=5A", i, bus.instr); end
            checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL bp_req[%0d] got=%0b exp=0", i, bus.imem_req); end
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        show("after accept");
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL bp_next_req got=%0b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h11) begin failures++; $display("FAIL bp_next_addr got=%02h exp=11", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL bp_next_valid got=%0b exp=0", bus.instr_valid); end
    endtask

    task automatic test_wrap;
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'hC3;
        step();
        bus.imem_ack = 1'b0;
        show("fetch 11");
        checks++; if (bus.instr !== 8'hC3) begin failures++; $display("FAIL wrap_instr1 got=%02h exp=C3", bus.instr); end
        checks++; if (bus.op !== OP_BRANCH) begin failures++; $display("FAIL wrap_op1 got=%0b exp=11", bus.op); end
        checks++; if (bus.instr_pc !== 8'h11) begin failures++; $display("FAIL wrap_pc1 got=%02h exp=11", bus.instr_pc); end
        bus.redirect = 1'b1; bus.redirect_target = 8'hFF;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_redir_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_redir_addr got=%02h exp=FF", bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h81;
        step();
        bus.imem_ack = 1'b0;
        show("fetch FF");
        checks++; if (bus.instr_pc !== 8'hFF) begin failures++; $display("FAIL wrap_pc2 got=%02h exp=FF", bus.instr_pc); end
        checks++; if (bus.op !== OP_STORE) begin failures++; $display("FAIL wrap_op2 got=%0b exp=10", bus.op); end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL wrap_addr got=%02h exp=00", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL wrap_req got=%0b exp=1", bus.imem_req); end
    endtask

    task automatic test_redirect_hold;
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h24;
        step();
        bus.imem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL rh_valid0 got=%0b exp=1", bus.instr_valid); end
        bus.redirect = 1'b1; bus.redirect_target = 8'h40; bus.instr_ready = 1'b0;
        step();
        bus.redirect = 1'b0;
        show("redirect hold nready");
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rh_valid1 got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 8'h40) begin failures++; $display("FAIL rh_addr1 got=%02h exp=40", bus.imem_addr); end
        checks++; if (bus.instr !== 8'h24) begin failures++; $display("FAIL rh_instr_stable got=%02h exp=24", bus.instr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h3C;
        step();
        bus.imem_ack = 1'b0;
        checks++; if (bus.instr_pc !== 8'h40) begin failures++; $display("FAIL rh_pc2 got=%02h exp=40", bus.instr_pc); end
        bus.redirect = 1'b1; bus.redirect_target = 8'h40; bus.instr_ready = 1'b1;
        step();
        bus.redirect = 1'b0; bus.instr_ready = 1'b0;
        show("redirect hold ready");
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rh_valid2 got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 8'h40) begin failures++; $display("FAIL rh_addr2 got=%02h exp=40", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rh_req2 got=%0b exp=1", bus.imem_req); end
        step();
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rh_noack_valid got=%0b exp=0", bus.instr_valid); end
    endtask

    task automatic test_redirect_inflight;
        // REQ at 0x40; redirect while the request is open, memory acks later
        bus.redirect = 1'b1; bus.redirect_target = 8'h80;
        step();
        bus.redirect = 1'b0;
        show("drain");
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rf_req got=%0b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h40) begin failures++; $display("FAIL rf_addr_held got=%02h exp=40", bus.imem_addr); end
        step();
        checks++; if (bus.imem_addr !== 8'h40) begin failures++; $display("FAIL rf_addr_held2 got=%02h exp=40", bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'hEE;
        step();
        bus.imem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rf_squashed_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 8'h80) begin failures++; $display("FAIL rf_addr_target got=%02h exp=80", bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h11;
        step();
        bus.imem_ack = 1'b0;
        show("fetch 80");
        checks++; if (bus.instr !== 8'h11) begin failures++; $display("FAIL rf_instr got=%02h exp=11", bus.instr); end
        checks++; if (bus.instr_pc !== 8'h80) begin failures++; $display("FAIL rf_instr_pc got=%02h exp=80", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        // second redirect while draining overwrites the target
        bus.redirect = 1'b1; bus.redirect_target = 8'h90;
        step();
        checks++; if (bus.imem_addr !== 8'h81) begin failures++; $display("FAIL rf2_addr_held got=%02h exp=81", bus.imem_addr); end
        bus.redirect_target = 8'hA0;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 8'h81) begin failures++; $display("FAIL rf2_addr_held2 got=%02h exp=81", bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h00;
        step();
        bus.imem_ack = 1'b0;
        show("drain done");
        checks++; if (bus.imem_addr !== 8'hA0) begin failures++; $display("FAIL rf2_addr_target got=%02h exp=A0", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rf2_valid got=%0b exp=0", bus.instr_valid); end
    endtask

    task automatic test_redirect_with_ack;
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h77; bus.redirect = 1'b1; bus.redirect_target = 8'h30;
        step();
        bus.imem_ack = 1'b0; bus.redirect = 1'b0;
        show("redirect+ack");
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ra_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 8'h30) begin failures++; $display("FAIL ra_addr got=%02h exp=30", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL ra_req got=%0b exp=1", bus.imem_req); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h99;
        step();
        bus.imem_ack = 1'b0;
        checks++; if (bus.instr !== 8'h99) begin failures++; $display("FAIL ra_instr got=%02h exp=99", bus.instr); end
        checks++; if (bus.instr_pc !== 8'h30) begin failures++; $display("FAIL ra_instr_pc got=%02h exp=30", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        checks++; if (bus.imem_addr !== 8'h31) begin failures++; $display("FAIL ra_next_addr got=%02h exp=31", bus.imem_addr); end
    endtask

    task automatic test_async_reset;
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL ar_pre_req got=%0b exp=1", bus.imem_req); end
        #2;
        reset = 1'b0;
        #1;
        show("async reset");
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL ar_req got=%0b exp=0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h10) begin failures++; $display("FAIL ar_addr got=%02h exp=10", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.instr !== 8'h00) begin failures++; $display("FAIL ar_instr got=%02h exp=00", bus.instr); end
        checks++; if (bus.instr_pc !== 8'h00) begin failures++; $display("FAIL ar_instr_pc got=%02h exp=00", bus.instr_pc); end
        // late ack from the abandoned fetch arrives while reset is held
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'hFF;
        step();
        step();
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL ar_restart_req got=%0b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h10) begin failures++; $display("FAIL ar_restart_addr got=%02h exp=10", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ar_restart_valid got=%0b exp=0", bus.instr_valid); end
        step();
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ar_idle_valid got=%0b exp=0", bus.instr_valid); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 8'h5A;
        step();
        bus.imem_ack = 1'b0;
        show("refetch after reset");
        checks++; if (bus.instr !== 8'h5A) begin failures++; $display("FAIL ar_instr2 got=%02h exp=5A", bus.instr); end
        checks++; if (bus.instr_pc !== 8'h10) begin failures++; $display("FAIL ar_instr_pc2 got=%02h exp=10", bus.instr_pc); end
        checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL ar_valid2 got=%0b exp=1", bus.instr_valid); end
    endtask

    initial begin
        reset               = 1'b0;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = 8'h00;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_backpressure();
        test_wrap();
        test_redirect_hold();
        test_redirect_inflight();
        test_redirect_with_ack();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
